// File: rtl/sysbus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sysbus_pkg : shared system-bus tag encodings, field offsets and FSM states  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package sysbus_pkg;

  localparam logic       SYSBUS_READ   = 1'b1;
  localparam logic       SYSBUS_WRITE  = 1'b0;
  localparam logic [3:0] SYSBUS_MEMORY = 4'h1;
  localparam logic [3:0] SYSBUS_INVAL  = 4'h8;

  // Tag layout: {op, type[3:0], id[7:0]}
  localparam int TAG_OP_BIT   = 12;
  localparam int TAG_TYPE_LSB = 8;
  localparam int TAG_TYPE_W   = 4;
  localparam int TAG_ID_LSB   = 0;
  localparam int TAG_ID_W     = 8;

  localparam int BEATS_PER_LINE = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HDR_ACK   = 3'd1,
    ST_WR_DATA   = 3'd2,
    ST_WR_COMMIT = 3'd3,
    ST_RD_WAIT   = 3'd4,
    ST_RD_RESP   = 3'd5,
    ST_INV_RESP  = 3'd6
  } sysbus_state_e;

  function automatic logic [12:0] sysbus_make_tag(input logic op, input logic [3:0] typ,
                                                  input logic [7:0] id);
    return {op, typ, id};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sysbus_line_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sysbus_line_ram : DEPTH x WIDTH single-port RAM, registered read, no reset  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sysbus_line_ram #(
  parameter int DEPTH  = 256,
  parameter int WIDTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Read register only updates on re, so it holds the line until the next read.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    if (re) begin
      r_rdata <= r_mem[addr];
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sysbus_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sysbus_mem_responder : memory-side system-bus responder with line storage   |
// | and injected invalidation beats.  Rev 1.0                                  |
// +----------------------------------------------------------------------------+
module sysbus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int DEPTH          = 256,
  parameter int READ_LATENCY   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack,
  input  logic                      inval_req,
  input  logic [BUS_DATA_WIDTH-1:0] inval_addr,
  output logic                      inval_ack
);
  import sysbus_pkg::*;

  localparam int c_IDX_W  = $clog2(DEPTH);
  localparam int c_LINE_W = BEATS_PER_LINE * BUS_DATA_WIDTH;
  localparam int c_OFS_W  = $clog2(c_LINE_W / 8);
  localparam int c_LAT_W  = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
  localparam logic [c_LAT_W-1:0] c_LAT_LAST =
    c_LAT_W'((READ_LATENCY >= 2) ? (READ_LATENCY - 2) : 0);
  localparam logic [BUS_TAG_WIDTH-1:0] c_INV_TAG =
    BUS_TAG_WIDTH'(sysbus_make_tag(1'b0, SYSBUS_INVAL, 8'h00));

  sysbus_state_e              r_state;
  logic [2:0]                 r_beat;
  logic [c_LAT_W-1:0]         r_lat;
  logic [c_IDX_W-1:0]         r_index;
  logic                       r_op;
  logic [TAG_ID_W-1:0]        r_id;
  logic                       r_drop;
  logic [BUS_DATA_WIDTH-1:0]  r_wbuf [BEATS_PER_LINE];
  logic [BUS_DATA_WIDTH-1:0]  r_rbuf [BEATS_PER_LINE];
  logic                       r_respcyc;
  logic [BUS_DATA_WIDTH-1:0]  r_resp;
  logic [BUS_TAG_WIDTH-1:0]   r_resptag;

  logic [c_IDX_W-1:0]         w_req_index;
  logic [TAG_TYPE_W-1:0]      w_req_type;
  logic                       w_accept_hdr;
  logic                       w_wr_beat;
  logic                       w_rd_launch;
  logic [2:0]                 w_next_beat;
  logic                       w_ram_we;
  logic [c_IDX_W-1:0]         w_ram_addr;
  logic [c_LINE_W-1:0]        w_wline;
  logic [c_LINE_W-1:0]        w_ram_rdata;
  logic [BUS_TAG_WIDTH-1:0]   w_rd_tag;

  assign w_req_index  = bus_req[c_OFS_W +: c_IDX_W];
  assign w_req_type   = bus_reqtag[TAG_TYPE_LSB +: TAG_TYPE_W];
  assign w_accept_hdr = (r_state == ST_IDLE) && !inval_req && bus_reqcyc;
  assign w_wr_beat    = (r_state == ST_WR_DATA) && bus_reqcyc;
  assign w_next_beat  = r_beat + 3'd1;
  assign w_ram_we     = (r_state == ST_WR_COMMIT);
  assign w_ram_addr   = w_ram_we ? r_index : w_req_index;
  assign w_rd_tag     = BUS_TAG_WIDTH'(sysbus_make_tag(SYSBUS_READ, SYSBUS_MEMORY, r_id));

  // The RAM is read speculatively on every accepted header, so the line is
  // already in the RAM output register by the HDR_ACK cycle.
  assign w_rd_launch =
    ((r_state == ST_HDR_ACK) && !r_drop && (r_op == SYSBUS_READ) && (READ_LATENCY == 1)) ||
    ((r_state == ST_RD_WAIT) && (r_lat == c_LAT_LAST));

  for (genvar gi = 0; gi < BEATS_PER_LINE; gi++) begin : g_pack
    assign w_wline[gi*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = r_wbuf[gi];
  end

  sysbus_line_ram #(
    .DEPTH  (DEPTH),
    .WIDTH  (c_LINE_W),
    .ADDR_W (c_IDX_W)
  ) u_line_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .re    (w_accept_hdr),
    .addr  (w_ram_addr),
    .wdata (w_wline),
    .rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_beat    <= '0;
      r_lat     <= '0;
      r_respcyc <= 1'b0;
      r_resp    <= '0;
      r_resptag <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (inval_req) begin
            r_resp    <= inval_addr;
            r_resptag <= c_INV_TAG;
            r_respcyc <= 1'b1;
            r_state   <= ST_INV_RESP;
          end else if (bus_reqcyc) begin
            r_index <= w_req_index;
            r_op    <= bus_reqtag[TAG_OP_BIT];
            r_id    <= bus_reqtag[TAG_ID_LSB +: TAG_ID_W];
            r_drop  <= (w_req_type != SYSBUS_MEMORY);
            r_state <= ST_HDR_ACK;
          end
        end
        ST_HDR_ACK: begin
          r_beat <= '0;
          r_lat  <= '0;
          if (r_drop) begin
            r_state <= ST_IDLE;
          end else if (r_op == SYSBUS_WRITE) begin
            r_state <= ST_WR_DATA;
          end else begin
            r_state <= (READ_LATENCY == 1) ? ST_RD_RESP : ST_RD_WAIT;
          end
        end
        ST_WR_DATA: begin
          if (bus_reqcyc) begin
            r_wbuf[r_beat] <= bus_req;
            r_beat         <= w_next_beat;
            if (r_beat == 3'd7) begin
              r_state <= ST_WR_COMMIT;
            end
          end
        end
        ST_WR_COMMIT: begin
          r_state <= ST_IDLE;
        end
        ST_RD_WAIT: begin
          if (r_lat == c_LAT_LAST) begin
            r_state <= ST_RD_RESP;
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end
        ST_RD_RESP: begin
          if (bus_respack) begin
            if (r_beat == 3'd7) begin
              r_respcyc <= 1'b0;
              r_state   <= ST_IDLE;
            end else begin
              r_beat <= w_next_beat;
              r_resp <= r_rbuf[w_next_beat];
            end
          end
        end
        ST_INV_RESP: begin
          if (bus_respack) begin
            r_respcyc <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      if (w_rd_launch) begin
        for (int k = 0; k < BEATS_PER_LINE; k++) begin
          r_rbuf[k] <= w_ram_rdata[k*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
        end
        r_resp    <= w_ram_rdata[BUS_DATA_WIDTH-1:0];
        r_resptag <= w_rd_tag;
        r_respcyc <= 1'b1;
      end
    end
  end

  // Write beats and the invalidation consume are acknowledged in the same cycle.
  assign bus_reqack  = !rst && ((r_state == ST_HDR_ACK) || w_wr_beat);
  assign inval_ack   = !rst && (r_state == ST_INV_RESP) && bus_respack;
  assign bus_respcyc = r_respcyc;
  assign bus_resp    = r_resp;
  assign bus_resptag = r_resptag;

endmodule
`default_nettype wire

// File: tb/tb_sysbus_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sysbus_mem_responder : scoreboard bench for sysbus_mem_responder         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_sysbus_mem_responder;
  import sysbus_pkg::*;

  localparam int W     = 64;
  localparam int TW    = 13;
  localparam int DEPTH = 256;
  localparam int LAT   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          bus_reqcyc;
  logic [W-1:0]  bus_req;
  logic [TW-1:0] bus_reqtag;
  logic          bus_reqack;
  logic          bus_respcyc;
  logic [W-1:0]  bus_resp;
  logic [TW-1:0] bus_resptag;
  logic          bus_respack;
  logic          inval_req;
  logic [W-1:0]  inval_addr;
  logic          inval_ack;

  sysbus_mem_responder #(
    .BUS_DATA_WIDTH (W),
    .BUS_TAG_WIDTH  (TW),
    .DEPTH          (DEPTH),
    .READ_LATENCY   (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus_reqcyc  (bus_reqcyc),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_reqack  (bus_reqack),
    .bus_respcyc (bus_respcyc),
    .bus_resp    (bus_resp),
    .bus_resptag (bus_resptag),
    .bus_respack (bus_respack),
    .inval_req   (inval_req),
    .inval_addr  (inval_addr),
    .inval_ack   (inval_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [W-1:0]  data;
  } beat_t;

  beat_t        sb[$];
  logic [W-1:0] model [DEPTH][8];
  int           n_chk = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           inv_ack_cyc = -1;
  logic         toggle_mode = 1'b0;

  task automatic check_eq(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    bus_respack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus_respack = toggle_mode ? ~bus_respack : 1'b1;
    end
  end

  // Response monitor: every visible response beat is compared with the queue head.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus_respcyc) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_beat", 1, 0);
        end else begin
          check_eq("resp_data", bus_resp, sb[0].data);
          check_eq("resp_tag", bus_resptag, sb[0].tag);
          check_eq("inval_ack", inval_ack, (sb[0].tag == 13'h0800) && bus_respack);
          if (bus_respack) begin
            if (sb[0].tag == 13'h0800) inv_ack_cyc = cyc;
            void'(sb.pop_front());
          end
        end
      end else if (inval_ack) begin
        check_eq("spurious_inval_ack", inval_ack, 0);
      end
    end
  end

  task automatic start_hdr(input logic [W-1:0] addr, input logic op, input logic [3:0] typ,
                           input logic [7:0] id);
    bus_req    = addr;
    bus_reqtag = {op, typ, id};
    bus_reqcyc = 1'b1;
  endtask

  task automatic wait_ack(output int ack_cyc);
    bit got = 1'b0;
    ack_cyc = -1;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (bus_reqack) begin
        got = 1'b1;
        ack_cyc = cyc;
      end
    end
    check_eq("hdr_ack", got, 1);
  endtask

  task automatic do_write(input logic [W-1:0] addr, input logic [7:0] id,
                          input logic [8*W-1:0] line, input int nbeats);
    int a;
    logic [7:0] idx;
    idx = addr[13:6];
    start_hdr(addr, SYSBUS_WRITE, SYSBUS_MEMORY, id);
    wait_ack(a);
    for (int k = 0; k < nbeats; k++) begin
      @(posedge clk);
      #1;
      bus_req = line[k*W +: W];
      @(negedge clk);
      check_eq("wr_beat_ack", bus_reqack, 1);
    end
    @(posedge clk);
    #1;
    bus_reqcyc = 1'b0;
    if (nbeats == 8) begin
      for (int k = 0; k < 8; k++) model[idx][k] = line[k*W +: W];
    end
  endtask

  task automatic rd_push(input logic [W-1:0] addr, input logic [7:0] id);
    beat_t b;
    logic [7:0] idx;
    idx = addr[13:6];
    for (int k = 0; k < 8; k++) begin
      b.tag  = {SYSBUS_READ, SYSBUS_MEMORY, id};
      b.data = model[idx][k];
      sb.push_back(b);
    end
  endtask

  task automatic rd_tail(input int ack_cyc);
    bit seen = 1'b0;
    bit done = 1'b0;
    @(posedge clk);
    #1;
    bus_reqcyc = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (bus_respcyc) begin
        seen = 1'b1;
        check_eq("rd_latency", cyc - ack_cyc, LAT);
      end
    end
    check_eq("rd_first_beat", seen, 1);
    for (int n = 0; n < 100 && !done; n++) begin
      @(posedge clk);
      if (sb.size() == 0) done = 1'b1;
    end
    check_eq("sb_drained", done, 1);
    sb.delete();
    @(negedge clk);
    check_eq("respcyc_low_after_last", bus_respcyc, 0);
  endtask

  task automatic do_read(input logic [W-1:0] addr, input logic [7:0] id);
    int a;
    rd_push(addr, id);
    start_hdr(addr, SYSBUS_READ, SYSBUS_MEMORY, id);
    wait_ack(a);
    rd_tail(a);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_ctl", {bus_respcyc, bus_reqack, inval_ack, bus_resptag}, 0);
    check_eq("rst_resp", bus_resp, 0);
  endtask

  function automatic logic [8*W-1:0] rand_line();
    logic [8*W-1:0] l;
    for (int k = 0; k < 8; k++) l[k*W +: W] = {$urandom, $urandom};
    return l;
  endfunction

  initial begin
    logic [8*W-1:0] line;
    beat_t b;
    int a1, a2;

    rst = 1'b1;
    bus_reqcyc = 1'b0;
    bus_req = '0;
    bus_reqtag = '0;
    inval_req = 1'b0;
    inval_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Known pattern write then read with respack held high.
    for (int k = 0; k < 8; k++) line[k*W +: W] = 64'((k + 1) * 17);
    do_write(64'h1000, 8'h05, line, 8);
    do_read(64'h1000, 8'h3C);

    // Same line with respack toggling.
    toggle_mode = 1'b1;
    do_read(64'h1000, 8'h7A);
    toggle_mode = 1'b0;
    @(posedge clk);
    #1;

    // Invalidation and a read header raised in the same cycle.
    b.tag  = 13'h0800;
    b.data = 64'hDEAD_BEC0;
    sb.push_back(b);
    rd_push(64'h1000, 8'h44);
    inv_ack_cyc = -1;
    inval_addr = 64'hDEAD_BEC0;
    inval_req = 1'b1;
    start_hdr(64'h1000, SYSBUS_READ, SYSBUS_MEMORY, 8'h44);
    @(posedge clk);
    #1;
    inval_req = 1'b0;
    wait_ack(a1);
    check_eq("inval_before_hdr", (inv_ack_cyc >= 0) && (a1 > inv_ack_cyc), 1);
    rd_tail(a1);

    // Index wrap: 0x4000 aliases line 0.
    do_write(64'h0, 8'h10, rand_line(), 8);
    do_write(64'h4000, 8'h11, rand_line(), 8);
    do_read(64'h0, 8'h12);

    // Reset in the middle of a write must not commit the partial line.
    do_write(64'h2000, 8'h21, rand_line(), 8);
    do_write(64'h2000, 8'h22, rand_line(), 3);
    rst = 1'b1;
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      check_reset_outputs();
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_read(64'h2000, 8'h23);

    // Non-memory header: acked once, dropped, back in IDLE the next cycle.
    start_hdr(64'h1000, SYSBUS_READ, 4'h2, 8'h99);
    wait_ack(a1);
    rd_push(64'h1000, 8'h9A);
    @(posedge clk);
    #1;
    start_hdr(64'h1000, SYSBUS_READ, SYSBUS_MEMORY, 8'h9A);
    wait_ack(a2);
    check_eq("bad_type_idle_next", a2 - a1, 2);
    rd_tail(a2);

    repeat (5) @(posedge clk);
    check_eq("sb_empty_end", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
